store_aligner: RTL and testbench
================================

STORE_ALIGNER -- requirements
Module: store_aligner

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of i_addr and o_addr.
REQ-002 Parameter DATA_WIDTH, default 32, store data width; only 32 is supported.
REQ-003 i_CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 i_RST  input  1  asynchronous, active-high reset.
REQ-005 i_valid  input  1  store request present this cycle.
REQ-006 o_ready  output  1  block accepts a request this cycle.
REQ-007 i_addr  input  ADDR_WIDTH  store byte address.
REQ-008 i_data  input  DATA_WIDTH  register value; the low-order bits hold the operand.
REQ-009 i_size  input  2  00 = byte (SB), 01 = half (SH), 10 = word (SW), 11 = reserved.
REQ-010 i_flush  input  1  drops any held store and clears any error.
REQ-011 o_valid  output  1  aligned memory write is held on the outputs.
REQ-012 i_ready  input  1  memory accepts the write this cycle.
REQ-013 o_addr  output  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
REQ-014 o_wdata  output  DATA_WIDTH  operand replicated into its byte lanes.
REQ-015 o_be  output  4  byte-lane write enables; bit n enables bits [8n+7:8n].
REQ-016 o_addr_err  output  1  address-error exception level.
REQ-017 o_badvaddr  output  ADDR_WIDTH  faulting address, valid while o_addr_err = 1.
REQ-018 i_err_ack  input  1  exception taken; clears the error.

Function
REQ-019 The block SHALL implement three states: EMPTY, FULL and ERR.
REQ-020 o_ready SHALL be 1 in EMPTY, and 1 in FULL only when i_ready = 1; it SHALL be 0 in ERR.
REQ-021 A request SHALL be accepted when i_valid and o_ready are both 1.
REQ-022 An accepted aligned request SHALL appear on the outputs, with o_valid = 1, on the next cycle (latency 1), and the state SHALL become FULL.
REQ-023 Byte lanes (little-endian): SB sets o_be = 1 << addr[1:0] and o_wdata = {4{data[7:0]}}; SH sets o_be = 0011 when addr[1] = 0 and 1100 otherwise, with o_wdata = {2{data[15:0]}}; SW sets o_be = 1111 and o_wdata = data.
REQ-024 Misalignment is SH with addr[0] = 1, SW with addr[1:0] != 0, or any request with i_size = 11.
REQ-025 An accepted misaligned request SHALL NOT produce o_valid; it SHALL capture o_badvaddr = i_addr, assert o_addr_err on the next cycle and enter ERR.
REQ-026 In FULL, the outputs SHALL hold stable until i_ready = 1.
REQ-027 In FULL with i_ready = 1 and a new accept in the same cycle, the new store SHALL replace the old one and the block SHALL stay FULL, with no bubble.
REQ-028 In FULL with i_ready = 1 and no accept, the block SHALL go to EMPTY and o_valid SHALL drop.
REQ-029 In ERR, i_err_ack = 1 SHALL clear o_addr_err and return the block to EMPTY; the block SHALL accept no requests until then.
REQ-030 i_flush SHALL have priority over every other input: the block goes to EMPTY, o_valid = 0, o_addr_err = 0, and a request in the same cycle is dropped.
REQ-031 When o_valid = 0, the o_be output SHALL be 0000.

Reset
REQ-032 Asserting i_RST SHALL, asynchronously, force EMPTY and set o_valid = 0, o_be = 0, o_wdata = 0, o_addr = 0, o_addr_err = 0 and o_badvaddr = 0.
REQ-033 Asserting i_RST mid-transfer SHALL discard the held store without issuing it.
REQ-034 The first accept SHALL be possible in the first cycle after i_RST deasserts.

Structure
REQ-035 The size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encodings SHALL live in the shared processor definitions package.
REQ-036 Lane generation (size + addr[1:0] -> o_be, o_wdata, misaligned) SHALL be a combinational sub-module named store_lane_gen; the handshake FSM and output registers SHALL be in store_aligner.

Verification
REQ-037 Test: SB, addr 0x1003, data 0x000000A5, i_ready = 1 -> next cycle o_addr = 0x1000, o_be = 1000, o_wdata = 0xA5A5A5A5.
REQ-038 Test: SH, addr 0x2002, data 0x1234BEEF -> o_be = 1100, o_wdata = 0xBEEFBEEF; hold i_ready = 0 for 3 cycles -> outputs stable and o_ready = 0.
REQ-039 Test: SW, addr 0x3002 -> o_valid never asserted, o_addr_err = 1 and o_badvaddr = 0x3002; i_err_ack -> EMPTY and o_ready = 1.
REQ-040 Test: back-to-back SW 0x10 then SW 0x14 with i_ready = 1 -> o_valid stays 1 on two consecutive cycles with addresses 0x10 then 0x14.
REQ-041 Test: i_flush in the same cycle as an accept while FULL -> next cycle o_valid = 0 and nothing is issued.
REQ-042 Test: i_RST pulse mid-cycle while FULL -> outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/store_aligner_pkg.sv
// Shared processor definitions for the store path: store size and
// handshake state encodings.
package store_aligner_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_ERR   = 2'b10
  } state_t;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational byte-lane generator: maps store size and the low address
// bits onto little-endian byte enables, replicated write data and a misalign flag.
module store_lane_gen
  import store_aligner_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  misaligned
);

  always_comb begin
    be         = 4'b0000;
    wdata      = '0;
    misaligned = 1'b0;
    case (size_t'(size))
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        wdata      = data;
        misaligned = (addr_lo != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_aligner.sv
// Store aligner: accepts a store request, aligns it into a word-addressed
// memory write with byte enables, and raises an address error on misalignment.
module store_aligner
  import store_aligner_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_size,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [3:0]            o_be,
  output logic                  o_addr_err,
  output logic [ADDR_WIDTH-1:0] o_badvaddr,
  input  logic                  i_err_ack,
  output state_t                o_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; a held write keeps every output stable until the sink's ready.
  state_t                state;
  logic                  accept;
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic                  lane_mis;

  store_lane_gen #(.DATA_WIDTH(DATA_WIDTH)) u_lane_gen (
    .size       (i_size),
    .addr_lo    (i_addr[1:0]),
    .data       (i_data),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .misaligned (lane_mis)
  );

  assign o_ready = (state == ST_EMPTY) || ((state == ST_FULL) && i_ready);
  assign accept  = i_valid && o_ready && !i_flush;
  assign o_state = state;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state      <= ST_EMPTY;
      o_valid    <= 1'b0;
      o_be       <= 4'b0000;
      o_wdata    <= '0;
      o_addr     <= '0;
      o_addr_err <= 1'b0;
      o_badvaddr <= '0;
    end else if (i_flush) begin
      state      <= ST_EMPTY;
      o_valid    <= 1'b0;
      o_be       <= 4'b0000;
      o_addr_err <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY, ST_FULL: begin
          if (accept && lane_mis) begin
            state      <= ST_ERR;
            o_valid    <= 1'b0;
            o_be       <= 4'b0000;
            o_addr_err <= 1'b1;
            o_badvaddr <= i_addr;
          end else if (accept) begin
            state   <= ST_FULL;
            o_valid <= 1'b1;
            o_be    <= lane_be;
            o_wdata <= lane_wdata;
            o_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
          end else if (state == ST_FULL && i_ready) begin
            state   <= ST_EMPTY;
            o_valid <= 1'b0;
            o_be    <= 4'b0000;
          end
        end
        ST_ERR: begin
          if (i_err_ack) begin
            state      <= ST_EMPTY;
            o_addr_err <= 1'b0;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          o_valid <= 1'b0;
          o_be    <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_aligner.sv
// Directed bench for store_aligner: inputs change just after a falling edge,
// outputs are checked on the following falling edge.
module tb_store_aligner;
  import store_aligner_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [1:0]  i_size;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_be;
  logic        o_addr_err;
  logic [31:0] o_badvaddr;
  logic        i_err_ack;
  state_t      o_state;

  int errors = 0;
  int checks = 0;

  logic [3:0]  held_be;
  logic [31:0] held_addr;
  logic [31:0] held_wdata;

  store_aligner dut (
    .i_CLK      (clk),
    .i_RST      (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .i_size     (i_size),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_addr     (o_addr),
    .o_wdata    (o_wdata),
    .o_be       (o_be),
    .o_addr_err (o_addr_err),
    .o_badvaddr (o_badvaddr),
    .i_err_ack  (i_err_ack),
    .o_state    (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    i_valid = v;
    i_size  = sz;
    i_addr  = a;
    i_data  = d;
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_ready = 1'b1; i_err_ack = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #12;
    check("rst_valid", o_valid, 1'b0);
    check("rst_be", o_be, 4'b0000);
    check("rst_addr", o_addr, 32'h0);
    check("rst_wdata", o_wdata, 32'h0);
    check("rst_err", o_addr_err, 1'b0);
    check("rst_badv", o_badvaddr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", o_ready, 1'b1);
    check("rst_state", o_state, ST_EMPTY);

    // SB at 0x1003
    drive(1'b1, 2'b00, 32'h1003, 32'h0000_00A5);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("sb_valid", o_valid, 1'b1);
    check("sb_addr", o_addr, 32'h1000);
    check("sb_be", o_be, 4'b1000);
    check("sb_wdata", o_wdata, 32'hA5A5_A5A5);
    check("sb_state", o_state, ST_FULL);
    step();
    check("sb_drain_valid", o_valid, 1'b0);
    check("sb_drain_be", o_be, 4'b0000);
    check("sb_drain_state", o_state, ST_EMPTY);

    // SH at 0x2002 held by back-pressure
    i_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h2002, 32'h1234_BEEF);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("sh_valid", o_valid, 1'b1);
    check("sh_addr", o_addr, 32'h2000);
    check("sh_be", o_be, 4'b1100);
    check("sh_wdata", o_wdata, 32'hBEEF_BEEF);
    check("sh_ready", o_ready, 1'b0);
    held_be = o_be; held_addr = o_addr; held_wdata = o_wdata;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, 32'h4000, 32'hDEAD_0000 + i);
      step();
      check("hold_valid", o_valid, 1'b1);
      check("hold_be", o_be, 4'b1100);
      check("hold_addr", o_addr, 32'h2000);
      check("hold_wdata", o_wdata, 32'hBEEF_BEEF);
      check("hold_ready", o_ready, 1'b0);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    i_ready = 1'b1;
    step();
    check("sh_drain_valid", o_valid, 1'b0);

    // Misaligned SW at 0x3002
    drive(1'b1, 2'b10, 32'h3002, 32'h5555_5555);
    step();
    drive(1'b1, 2'b10, 32'h0040, 32'h6666_6666);
    check("mis_valid", o_valid, 1'b0);
    check("mis_err", o_addr_err, 1'b1);
    check("mis_badv", o_badvaddr, 32'h3002);
    check("mis_ready", o_ready, 1'b0);
    check("mis_state", o_state, ST_ERR);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("err_block_valid", o_valid, 1'b0);
    check("err_block_err", o_addr_err, 1'b1);
    check("err_block_badv", o_badvaddr, 32'h3002);
    i_err_ack = 1'b1;
    step();
    i_err_ack = 1'b0;
    check("ack_err", o_addr_err, 1'b0);
    check("ack_ready", o_ready, 1'b1);
    check("ack_state", o_state, ST_EMPTY);

    // Reserved size and misaligned half both fault
    drive(1'b1, 2'b11, 32'h0050, 32'h0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("rsvd_err", o_addr_err, 1'b1);
    check("rsvd_valid", o_valid, 1'b0);
    i_err_ack = 1'b1;
    step();
    i_err_ack = 1'b0;
    drive(1'b1, 2'b01, 32'h0061, 32'h0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("sh_mis_err", o_addr_err, 1'b1);
    check("sh_mis_badv", o_badvaddr, 32'h0061);
    i_err_ack = 1'b1;
    step();
    i_err_ack = 1'b0;
    check("sh_mis_ack", o_addr_err, 1'b0);

    // Back-to-back SW 0x10, 0x14
    drive(1'b1, 2'b10, 32'h0010, 32'h1111_1111);
    step();
    check("b2b0_valid", o_valid, 1'b1);
    check("b2b0_addr", o_addr, 32'h0010);
    check("b2b0_wdata", o_wdata, 32'h1111_1111);
    check("b2b0_be", o_be, 4'b1111);
    check("b2b0_ready", o_ready, 1'b1);
    drive(1'b1, 2'b10, 32'h0014, 32'h2222_2222);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("b2b1_valid", o_valid, 1'b1);
    check("b2b1_addr", o_addr, 32'h0014);
    check("b2b1_wdata", o_wdata, 32'h2222_2222);
    step();
    check("b2b_drain", o_valid, 1'b0);

    // Flush with a same-cycle accept while FULL
    drive(1'b1, 2'b10, 32'h0020, 32'h3333_3333);
    step();
    check("fl_full", o_valid, 1'b1);
    drive(1'b1, 2'b10, 32'h0024, 32'h4444_4444);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("fl_valid", o_valid, 1'b0);
    check("fl_be", o_be, 4'b0000);
    check("fl_state", o_state, ST_EMPTY);
    step();
    check("fl_after", o_valid, 1'b0);

    // Other lane patterns
    drive(1'b1, 2'b00, 32'h1001, 32'hFFFF_FF3C);
    step();
    check("sb1_be", o_be, 4'b0010);
    check("sb1_wdata", o_wdata, 32'h3C3C_3C3C);
    drive(1'b1, 2'b01, 32'h2000, 32'hAAAA_1357);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("sh0_be", o_be, 4'b0011);
    check("sh0_wdata", o_wdata, 32'h1357_1357);
    check("sh0_addr", o_addr, 32'h2000);
    step();

    // Asynchronous reset while FULL, then accept in first cycle after
    drive(1'b1, 2'b10, 32'h0030, 32'h7777_7777);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("ar_full", o_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", o_valid, 1'b0);
    check("ar_be", o_be, 4'b0000);
    check("ar_addr", o_addr, 32'h0);
    check("ar_wdata", o_wdata, 32'h0);
    check("ar_state", o_state, ST_EMPTY);
    step();
    rst = 1'b0;
    drive(1'b1, 2'b10, 32'h0034, 32'h8888_8888);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("first_valid", o_valid, 1'b1);
    check("first_addr", o_addr, 32'h0034);
    check("first_wdata", o_wdata, 32'h8888_8888);
    step();
    check("first_drain", o_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
